// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and a 4-bit flag register.
// A write can be forwarded to either read port in the same cycle when BYPASS is set.

module regfile_cell #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] data
);
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (we) data_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;
endmodule

module regfile_rd_port #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int BYPASS     = 1
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [SEL_WIDTH-1:0]                sel,
  input  logic                                byp_en,
  input  logic [SEL_WIDTH-1:0]                wsel,
  input  logic [DATA_WIDTH-1:0]               wdata,
  output logic [DATA_WIDTH-1:0]               data,
  output logic                                oob
);
  // Decoded mux rather than regs[sel] so selects past NUM_REGS never index out of range.
  always_comb begin
    data = '0;
    oob  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        oob  = 1'b0;
        data = regs[i];
      end
    end
    if (BYPASS != 0 && byp_en && !oob && wsel == sel) data = wdata;
  end
endmodule

module regfile_bypass #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_WIDTH-1:0]  read1RegSel,
  input  logic [SEL_WIDTH-1:0]  read2RegSel,
  input  logic [SEL_WIDTH-1:0]  writeRegSel,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  writeEn,
  output logic [DATA_WIDTH-1:0] read1Data,
  output logic [DATA_WIDTH-1:0] read2Data,
  input  logic                  flagWrEn,
  input  logic [3:0]            flagsIn,
  output logic [3:0]            flagsOut,
  output logic                  err
);
  localparam bit CFG_ERR = (SEL_WIDTH != $clog2(NUM_REGS));

  typedef struct packed {
    logic                  en;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t                             wr_req;
  logic                                wr_oob;
  logic [NUM_REGS-1:0]                 we_vec;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [1:0][SEL_WIDTH-1:0]           rd_sel;
  logic [1:0][DATA_WIDTH-1:0]          rd_data;
  logic [1:0]                          rd_oob;
  logic [3:0]                          flags_d, flags_q;

  // Reset masks the write: it wins over writeEn for both storage and the bypass.
  assign wr_req = '{en: writeEn & ~rst, sel: writeRegSel, data: writeData};

  always_comb begin
    we_vec = '0;
    wr_oob = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (writeRegSel == SEL_WIDTH'(i)) begin
        wr_oob    = 1'b0;
        we_vec[i] = wr_req.en;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      regfile_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .we    (we_vec[g]),
        .wdata (wr_req.data),
        .data  (regs[g])
      );
    end
  endgenerate

  assign rd_sel = {read2RegSel, read1RegSel};

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      regfile_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .SEL_WIDTH  (SEL_WIDTH),
        .BYPASS     (BYPASS)
      ) u_rd (
        .regs   (regs),
        .sel    (rd_sel[p]),
        .byp_en (wr_req.en),
        .wsel   (wr_req.sel),
        .wdata  (wr_req.data),
        .data   (rd_data[p]),
        .oob    (rd_oob[p])
      );
    end
  endgenerate

  assign read1Data = rd_data[0];
  assign read2Data = rd_data[1];

  always_comb begin
    flags_d = flags_q;
    if (flagWrEn) flags_d = flagsIn;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flagsOut = flags_q;
  assign err      = CFG_ERR | (writeEn & wr_oob) | (|rd_oob);
endmodule
